// File: rtl/bch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bch_encoder
// Description : Systematic binary BCH(31,16), t=3 encoder over GF(2^5)
//               (primitive polynomial x^5+x^2+1). The 15 parity bits come from
//               a serial division LFSR by g(x) = 0x8FAF (octal 107657), fed
//               one message bit per clock, MSB first. Valid/ready message
//               input and valid/ready codeword output.
//               Optional build macro BCH_ENC_ERR_INJECT_EN adds an err_mask
//               input that is latched with the message and XORed onto the
//               finished codeword, for decoder testing.
// Revision    : 1.0 - initial release
// ============================================================================
module bch_encoder (
    input  logic        clk,
    input  logic        reset,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [30:0] err_mask,
`endif
    input  logic [15:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [30:0] cw_data,
    output logic        cw_valid,
    input  logic        cw_ready,
    output logic        busy
);

    // Low 15 coefficients of g(x); the x^15 term is implicit in the LFSR.
    localparam logic [14:0] c_gen_tail = 15'h0FAF;
    localparam logic [3:0]  c_last_step = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] msg_q,      msg_d;
    logic [14:0] lfsr_q,     lfsr_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [30:0] cw_data_q,  cw_data_d;
    logic        cw_valid_q, cw_valid_d;
    logic [30:0] err_q,      err_d;

    logic        w_feedback;
    logic [14:0] w_lfsr_step;
    logic [30:0] w_inject;

    // One division step: message bit MSB first (index 15-cnt == ~cnt).
    always_comb begin
        w_feedback  = msg_q[~cnt_q] ^ lfsr_q[14];
        w_lfsr_step = {lfsr_q[13:0], 1'b0} ^ ({15{w_feedback}} & c_gen_tail);
    end

`ifdef BCH_ENC_ERR_INJECT_EN
    // Mask is captured alongside the message so later input changes are harmless.
    always_comb begin
        w_inject = err_mask;
    end
`else
    // Without injection the latched mask stays zero and the codeword is pure.
    always_comb begin
        w_inject = 31'd0;
    end
`endif

    // Next-state and datapath control for IDLE -> SHIFT -> OUT.
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        cw_data_d  = cw_data_q;
        cw_valid_d = cw_valid_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (msg_valid) begin
                    msg_d   = msg_data;
                    err_d   = w_inject;
                    lfsr_d  = 15'd0;
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                lfsr_d = w_lfsr_step;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == c_last_step) begin
                    // Final step: publish codeword with the freshly computed parity.
                    cw_data_d  = {msg_q, w_lfsr_step} ^ err_q;
                    cw_valid_d = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (cw_ready) begin
                    cw_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                cw_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset aborts any codeword in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            msg_q      <= 16'd0;
            lfsr_q     <= 15'd0;
            cnt_q      <= 4'd0;
            cw_data_q  <= 31'd0;
            cw_valid_q <= 1'b0;
            err_q      <= 31'd0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            cw_data_q  <= cw_data_d;
            cw_valid_q <= cw_valid_d;
            err_q      <= err_d;
        end
    end

    // Handshake/status outputs decoded from the registered state.
    always_comb begin
        msg_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        cw_data   = cw_data_q;
        cw_valid  = cw_valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bch_encoder
// Description : Directed self-checking bench for bch_encoder with
//               hand-computed BCH(31,16) codewords.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [30:0] cw_data;
    logic        cw_valid;
    logic        cw_ready;
    logic        busy;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [30:0] err_mask;
`endif

    int checks;
    int failures;

    bch_encoder u_dut (
        .clk       (clk),
        .reset     (reset),
`ifdef BCH_ENC_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .cw_data   (cw_data),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept on edge 0, parity after edge 16, handshake on edge 17.
    task automatic run_msg(input logic [15:0] m, input logic [30:0] exp, input string tag);
        msg_data  = m;
        msg_valid = 1'b1;
        cw_ready  = 1'b0;
        tick();
        chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready_after_accept"}, {31'd0, msg_ready}, 32'd0);
        msg_valid = 1'b0;
        msg_data  = ~m;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk({tag, "_valid_early"}, {31'd0, cw_valid}, 32'd0);
        end
        tick();
        chk({tag, "_valid_edge16"}, {31'd0, cw_valid}, 32'd1);
        chk({tag, "_cw_data"}, {1'b0, cw_data}, {1'b0, exp});
        cw_ready = 1'b1;
        tick();
        chk({tag, "_valid_after_hs"}, {31'd0, cw_valid}, 32'd0);
        chk({tag, "_ready_after_hs"}, {31'd0, msg_ready}, 32'd1);
        chk({tag, "_cw_hold"}, {1'b0, cw_data}, {1'b0, exp});
        cw_ready = 1'b0;
    endtask

    initial begin
        int first_v;
        int second_v;
        logic [30:0] first_d;
        logic [30:0] second_d;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        msg_data  = 16'h0000;
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
        err_mask  = 31'd0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_msg_ready", {31'd0, msg_ready}, 32'd1);
        chk("rst_cw_valid",  {31'd0, cw_valid},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_cw_data",   {1'b0, cw_data},    32'd0);

        run_msg(16'h0000, 31'h00000000, "m0000");
        run_msg(16'h0001, 31'h00008FAF, "m0001");
        run_msg(16'h0002, 31'h00011F5E, "m0002");
        run_msg(16'h0003, 31'h000190F1, "m0003");
        run_msg(16'h0005, 31'h0002B113, "m0005");

        // Stall in OUT with a competing message offered.
        msg_data  = 16'h0003;
        msg_valid = 1'b1;
        tick();
        msg_data = 16'h0001;
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_cw_data",   {1'b0, cw_data},   32'h000190F1);
            chk("stall_msg_ready", {31'd0, msg_ready}, 32'd0);
            chk("stall_cw_valid",  {31'd0, cw_valid},  32'd1);
            tick();
        end
        cw_ready = 1'b1;
        tick();
        chk("stall_release_busy",  {31'd0, busy},     32'd0);
        chk("stall_release_valid", {31'd0, cw_valid}, 32'd0);
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
        tick();
        chk("idle_no_accept", {31'd0, busy}, 32'd0);

        // Back-to-back with sink always ready: codewords 18 cycles apart.
        cw_ready  = 1'b1;
        msg_data  = 16'h0002;
        msg_valid = 1'b1;
        tick();
        msg_data = 16'h0003;
        first_v  = -1;
        second_v = -1;
        first_d  = '0;
        second_d = '0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (cw_valid === 1'b1) begin
                if (first_v < 0) begin
                    first_v = e;
                    first_d = cw_data;
                end else if (second_v < 0) begin
                    second_v = e;
                    second_d = cw_data;
                end
            end
        end
        msg_valid = 1'b0;
        chk("b2b_first_edge",  first_v,  32'd16);
        chk("b2b_second_edge", second_v, 32'd34);
        chk("b2b_first_data",  {1'b0, first_d},  32'h00011F5E);
        chk("b2b_second_data", {1'b0, second_d}, 32'h000190F1);
        for (int i = 0; i < 20; i++) tick();
        cw_ready = 1'b0;
        chk("b2b_drained", {31'd0, busy}, 32'd0);

        // Reset at shift step 8 aborts the codeword.
        msg_data  = 16'h0001;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy_async",  {31'd0, busy},     32'd0);
        chk("abort_cw_data",     {1'b0, cw_data},   32'd0);
        tick();
        reset = 1'b0;
        first_v = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (cw_valid !== 1'b0) first_v++;
        end
        chk("abort_never_valid", first_v, 32'd0);
        chk("abort_msg_ready",   {31'd0, msg_ready}, 32'd1);
        run_msg(16'h0001, 31'h00008FAF, "after_abort");

`ifdef BCH_ENC_ERR_INJECT_EN
        err_mask = 31'h40000401;
        run_msg(16'h0001, 31'h40008BAE, "inject");
        err_mask = 31'd0;
        run_msg(16'h0001, 31'h00008FAF, "inject_off");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
